// File: rtl/uart_rx_param_if.sv
// Receive-side bundle between uart_rx_param and its consumer.
// Latency: none, wires only.
// Backpressure: consumer pops with rd_en; the receiver never stalls the line and drops on a full FIFO.
// Ports: rd_en (consumer -> receiver); rd_data, rd_valid, fifo_count,
//        frame_err, parity_err, overrun, busy (receiver -> consumer).
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8,
   parameter int CNT_W     = 3
);
   logic                 rd_en;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic [CNT_W-1:0]     fifo_count;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;
   logic                 busy;

   modport master (
      input  rd_en,
      output rd_data, rd_valid, fifo_count, frame_err, parity_err, overrun, busy
   );

   modport slave (
      output rd_en,
      input  rd_data, rd_valid, fifo_count, frame_err, parity_err, overrun, busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with show-ahead receive FIFO and per-frame error pulses.
// Latency: rd_valid rises 1 clock after the tick of the final stop-bit sample.
// Backpressure: none on the line; a good frame arriving at a full FIFO without a pop is dropped (overrun).
// Ports: clock, reset (sync, active-high), tick (OVERSAMPLE x baud strobe),
//        rx (async serial in, idle high), rd (uart_rx_param_if.master: pop side + status).
module uart_rx_param #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            tick,
   input  logic            rx,
   uart_rx_param_if.master rd
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [TW-1:0]    T_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0]    T_FULL = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0]    B_LAST = BW'(DATA_BITS - 1);
   localparam logic             ODD    = (PARITY_MODE == 2);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t state, state_nxt;

   logic                 rx_meta, rxs;
   logic [TW-1:0]        tcnt;
   logic [BW-1:0]        bidx;
   logic                 scnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad, stop_bad;
   logic                 frame_err_q, parity_err_q, overrun_q;

   logic mid_half, mid_full, stop_last;
   logic shift_en, par_en, stop_en, done, fe_now, good;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        rptr, wptr;
   logic [CNT_W-1:0]     count;
   logic                 full, rd_valid_i, pop, push;

   assign mid_half  = tick && (tcnt == T_HALF);
   assign mid_full  = tick && (tcnt == T_FULL);
   assign stop_last = (scnt == 1'(STOP_BITS - 1));
   // Current stop sample folded in, so the decision is available on the last sampling tick.
   assign fe_now    = stop_bad | ~rxs;
   assign good      = ~fe_now & ~par_bad;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      stop_en   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:      if (tick && !rxs) state_nxt = START;
         // Start bit must still be low at its midpoint, otherwise it was a glitch.
         START:     if (mid_half) state_nxt = rxs ? IDLE : DATA;
         DATA: begin
            if (mid_full) begin
               shift_en = 1'b1;
               if (bidx == B_LAST) state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (mid_full) begin
               par_en    = 1'b1;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (mid_full) begin
               stop_en = 1'b1;
               if (stop_last) begin
                  done = 1'b1;
                  // Leave at mid-stop so a back-to-back start edge is not missed;
                  // a low stop means a possible break, so wait for the line to recover.
                  state_nxt = fe_now ? WAIT_HIGH : IDLE;
               end
            end
         end
         WAIT_HIGH: if (rxs) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta      <= 1'b1;
         rxs          <= 1'b1;
         tcnt         <= '0;
         bidx         <= '0;
         scnt         <= 1'b0;
         shreg        <= '0;
         par_bad      <= 1'b0;
         stop_bad     <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;

         // Bit timing restarts on every state change and after every mid-bit sample.
         if (state_nxt != state || mid_full) tcnt <= '0;
         else if (tick)                      tcnt <= tcnt + TW'(1);

         if (state == START) begin
            bidx     <= '0;
            scnt     <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
         end

         if (shift_en) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            bidx  <= bidx + BW'(1);
         end

         if (par_en) par_bad <= (((^shreg) ^ rxs) != ODD);

         if (stop_en) begin
            stop_bad <= fe_now;
            scnt     <= scnt + 1'b1;
         end

         frame_err_q  <= done & fe_now;
         parity_err_q <= done & ~fe_now & par_bad;
         overrun_q    <= done & good & full & ~pop;
      end
   end

   assign full       = (count == C_FULL);
   assign rd_valid_i = (count != '0);
   assign pop        = rd.rd_en & rd_valid_i;
   // A pop in the completion cycle frees the slot, so a full FIFO still accepts the frame.
   assign push       = done & good & (~full | pop);

   always_ff @(posedge clock) begin
      if (push) mem[wptr] <= shreg;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; gating keeps rd_data at zero while empty.
   assign rd.rd_data    = rd_valid_i ? mem[rptr] : '0;
   assign rd.rd_valid   = rd_valid_i;
   assign rd.fifo_count = count;
   assign rd.frame_err  = frame_err_q;
   assign rd.parity_err = parity_err_q;
   assign rd.overrun    = overrun_q;
   assign rd.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
   logic clock = 1'b0;
   logic reset;
   logic tick;
   logic rx0, rx1, rx2;

   int checks = 0;
   int errors = 0;
   int fe_cnt [3];
   int pe_cnt [3];
   int ov_cnt [3];

   always #5 clock = ~clock;

   uart_rx_param_if #(.DATA_BITS(8), .CNT_W(3)) if0 ();
   uart_rx_param_if #(.DATA_BITS(8), .CNT_W(3)) if1 ();
   uart_rx_param_if #(.DATA_BITS(8), .CNT_W(3)) if2 ();

   // dut0: 8N1, dut1: 8E1, dut2: 8N2
   uart_rx_param #(.PARITY_MODE(0), .STOP_BITS(1)) dut0 (
      .clock(clock), .reset(reset), .tick(tick), .rx(rx0), .rd(if0));
   uart_rx_param #(.PARITY_MODE(1), .STOP_BITS(1)) dut1 (
      .clock(clock), .reset(reset), .tick(tick), .rx(rx1), .rd(if1));
   uart_rx_param #(.PARITY_MODE(0), .STOP_BITS(2)) dut2 (
      .clock(clock), .reset(reset), .tick(tick), .rx(rx2), .rd(if2));

   initial begin
      for (int i = 0; i < 3; i++) begin
         fe_cnt[i] = 0;
         pe_cnt[i] = 0;
         ov_cnt[i] = 0;
      end
   end

   always @(negedge clock) begin
      if (if0.frame_err)  fe_cnt[0] = fe_cnt[0] + 1;
      if (if1.frame_err)  fe_cnt[1] = fe_cnt[1] + 1;
      if (if2.frame_err)  fe_cnt[2] = fe_cnt[2] + 1;
      if (if0.parity_err) pe_cnt[0] = pe_cnt[0] + 1;
      if (if1.parity_err) pe_cnt[1] = pe_cnt[1] + 1;
      if (if2.parity_err) pe_cnt[2] = pe_cnt[2] + 1;
      if (if0.overrun)    ov_cnt[0] = ov_cnt[0] + 1;
      if (if1.overrun)    ov_cnt[1] = ov_cnt[1] + 1;
      if (if2.overrun)    ov_cnt[2] = ov_cnt[2] + 1;
   end

   task automatic set_line(input int d, input logic v);
      case (d)
         0:       rx0 = v;
         1:       rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   task automatic set_pop(input int d, input logic v);
      case (d)
         0:       if0.rd_en = v;
         1:       if1.rd_en = v;
         default: if2.rd_en = v;
      endcase
   endtask

   function automatic int get_count(input int d);
      case (d)
         0:       return int'(if0.fifo_count);
         1:       return int'(if1.fifo_count);
         default: return int'(if2.fifo_count);
      endcase
   endfunction

   function automatic logic [7:0] get_data(input int d);
      case (d)
         0:       return if0.rd_data;
         1:       return if1.rd_data;
         default: return if2.rd_data;
      endcase
   endfunction

   function automatic logic [15:0] f8n1(input logic [7:0] v);
      return {6'b0, 1'b1, v, 1'b0};
   endfunction

   function automatic logic [15:0] f8p1(input logic [7:0] v, input logic p);
      return {5'b0, 1'b1, p, v, 1'b0};
   endfunction

   function automatic logic [15:0] f8n2(input logic [7:0] v, input logic s2);
      return {5'b0, s2, 1'b1, v, 1'b0};
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      if0.rd_en = 1'b0; if1.rd_en = 1'b0; if2.rd_en = 1'b0;
      wait_clks(3);
      reset = 1'b0;
   endtask

   // Drives nbits bit periods (16 clocks each, bit 0 first); pop_edge raises rd_en for
   // the cycle ending at that edge. push_edge reports the first edge (counted from the
   // start-bit edge) after which fifo_count changed, or -1.
   task automatic send_frame(input int d, input logic [15:0] bits, input int nbits,
                             input int pop_edge, output int push_edge);
      int c0;
      c0 = get_count(d);
      push_edge = -1;
      for (int c = 0; c < nbits * 16; c++) begin
         set_line(d, bits[c / 16]);
         set_pop(d, (c + 1) == pop_edge);
         @(posedge clock);
         #1;
         if (push_edge < 0 && get_count(d) != c0) push_edge = c + 1;
      end
      set_pop(d, 1'b0);
      set_line(d, 1'b1);
   endtask

   task automatic pop_one(input int d);
      set_pop(d, 1'b1);
      wait_clks(1);
      set_pop(d, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", if0.rd_valid); end
      checks++; if (if0.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if0.fifo_count); end
      checks++; if (if0.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", if0.rd_data); end
      checks++; if ({if0.busy, if0.frame_err, if0.parity_err, if0.overrun} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b exp 0000", {if0.busy, if0.frame_err, if0.parity_err, if0.overrun}); end
      rx0 = 1'b0;
      wait_clks(40);
      checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b exp 1", if0.busy); end
      do_reset();
      wait_clks(200);
      checks++; if ({if0.busy, if0.rd_valid} !== 2'b00) begin
         errors++; $display("FAIL midframe_abort got busy/valid %b exp 00", {if0.busy, if0.rd_valid}); end
   endtask

   task automatic test_basic();
      int pe, f0, p0, o0;
      do_reset();
      f0 = fe_cnt[0]; p0 = pe_cnt[0]; o0 = ov_cnt[0];
      send_frame(0, f8n1(8'h4D), 10, 0, pe);
      checks++; if (pe !== 155) begin errors++; $display("FAIL basic_latency got edge %0d exp 155", pe); end
      checks++; if (if0.rd_data !== 8'h4D) begin errors++; $display("FAIL basic_data got %h exp 4d", if0.rd_data); end
      checks++; if (if0.fifo_count !== 3'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", if0.fifo_count); end
      checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", if0.busy); end
      checks++; if (fe_cnt[0] - f0 + pe_cnt[0] - p0 + ov_cnt[0] - o0 !== 0) begin
         errors++; $display("FAIL basic_no_err got %0d pulses exp 0", fe_cnt[0] - f0 + pe_cnt[0] - p0 + ov_cnt[0] - o0); end
   endtask

   task automatic test_glitch();
      int f0, p0;
      do_reset();
      f0 = fe_cnt[0]; p0 = pe_cnt[0];
      rx0 = 1'b0;
      wait_clks(5);
      checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b exp 1", if0.busy); end
      rx0 = 1'b1;
      wait_clks(20);
      checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got %b exp 0", if0.busy); end
      checks++; if (if0.fifo_count !== 3'd0) begin errors++; $display("FAIL glitch_count got %0d exp 0", if0.fifo_count); end
      checks++; if (fe_cnt[0] - f0 + pe_cnt[0] - p0 !== 0) begin
         errors++; $display("FAIL glitch_no_err got %0d pulses exp 0", fe_cnt[0] - f0 + pe_cnt[0] - p0); end
   endtask

   task automatic test_parity();
      int pe, f0, p0;
      do_reset();
      f0 = fe_cnt[1]; p0 = pe_cnt[1];
      send_frame(1, f8p1(8'h07, 1'b0), 11, 0, pe);
      wait_clks(2);
      checks++; if (pe_cnt[1] - p0 !== 1) begin errors++; $display("FAIL parity_bad_pulse got %0d exp 1", pe_cnt[1] - p0); end
      checks++; if (fe_cnt[1] - f0 !== 0) begin errors++; $display("FAIL parity_bad_fe got %0d exp 0", fe_cnt[1] - f0); end
      checks++; if (if1.fifo_count !== 3'd0) begin errors++; $display("FAIL parity_bad_count got %0d exp 0", if1.fifo_count); end
      wait_clks(5);
      send_frame(1, f8p1(8'h07, 1'b1), 11, 0, pe);
      checks++; if (pe !== 171) begin errors++; $display("FAIL parity_ok_latency got edge %0d exp 171", pe); end
      checks++; if (if1.rd_data !== 8'h07) begin errors++; $display("FAIL parity_ok_data got %h exp 07", if1.rd_data); end
      checks++; if (pe_cnt[1] - p0 !== 1) begin errors++; $display("FAIL parity_ok_no_pulse got %0d exp 1", pe_cnt[1] - p0); end
   endtask

   task automatic test_overrun();
      int pe, o0;
      logic [7:0] exp_v;
      do_reset();
      o0 = ov_cnt[0];
      for (int i = 1; i <= 5; i++) begin
         exp_v = 8'(i * 17);
         send_frame(0, f8n1(exp_v), 10, 0, pe);
      end
      wait_clks(2);
      checks++; if (if0.fifo_count !== 3'd4) begin errors++; $display("FAIL ovr_count got %0d exp 4", if0.fifo_count); end
      checks++; if (ov_cnt[0] - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ov_cnt[0] - o0); end
      for (int i = 1; i <= 4; i++) begin
         exp_v = 8'(i * 17);
         checks++; if (if0.rd_valid !== 1'b1 || get_data(0) !== exp_v) begin
            errors++; $display("FAIL ovr_pop%0d got valid %b data %h exp 1 %h", i, if0.rd_valid, get_data(0), exp_v); end
         pop_one(0);
      end
      checks++; if (if0.rd_valid !== 1'b0 || if0.fifo_count !== 3'd0) begin
         errors++; $display("FAIL ovr_empty got valid %b count %0d exp 0 0", if0.rd_valid, if0.fifo_count); end
   endtask

   task automatic test_full_pop();
      int pe, o0;
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h66;
      do_reset();
      send_frame(0, f8n1(8'h11), 10, 0, pe);
      send_frame(0, f8n1(8'h22), 10, 0, pe);
      send_frame(0, f8n1(8'h33), 10, 0, pe);
      send_frame(0, f8n1(8'h44), 10, 0, pe);
      o0 = ov_cnt[0];
      send_frame(0, f8n1(8'h66), 10, 155, pe);
      wait_clks(2);
      checks++; if (ov_cnt[0] - o0 !== 0) begin errors++; $display("FAIL fullpop_overrun got %0d exp 0", ov_cnt[0] - o0); end
      checks++; if (if0.fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_count got %0d exp 4", if0.fifo_count); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (get_data(0) !== exp_q[i]) begin
            errors++; $display("FAIL fullpop_order%0d got %h exp %h", i, get_data(0), exp_q[i]); end
         pop_one(0);
      end
   endtask

   task automatic test_break();
      int pe, f0, p0;
      do_reset();
      f0 = fe_cnt[0]; p0 = pe_cnt[0];
      rx0 = 1'b0;
      wait_clks(480);
      checks++; if (fe_cnt[0] - f0 !== 1) begin errors++; $display("FAIL break_fe got %0d exp 1", fe_cnt[0] - f0); end
      checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b exp 1", if0.busy); end
      checks++; if (if0.fifo_count !== 3'd0 || pe_cnt[0] - p0 !== 0) begin
         errors++; $display("FAIL break_nopush got count %0d pe %0d exp 0 0", if0.fifo_count, pe_cnt[0] - p0); end
      rx0 = 1'b1;
      wait_clks(5);
      checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL break_release got %b exp 0", if0.busy); end
      send_frame(0, f8n1(8'hA5), 10, 0, pe);
      checks++; if (pe !== 155 || if0.rd_data !== 8'hA5) begin
         errors++; $display("FAIL break_next got edge %0d data %h exp 155 a5", pe, if0.rd_data); end
      checks++; if (fe_cnt[0] - f0 !== 1) begin errors++; $display("FAIL break_next_fe got %0d exp 1", fe_cnt[0] - f0); end
   endtask

   task automatic test_stop2();
      int pe, f0;
      do_reset();
      f0 = fe_cnt[2];
      send_frame(2, f8n2(8'h3C, 1'b0), 11, 0, pe);
      wait_clks(5);
      checks++; if (fe_cnt[2] - f0 !== 1) begin errors++; $display("FAIL stop2_fe got %0d exp 1", fe_cnt[2] - f0); end
      checks++; if (if2.fifo_count !== 3'd0 || if2.busy !== 1'b0) begin
         errors++; $display("FAIL stop2_drop got count %0d busy %b exp 0 0", if2.fifo_count, if2.busy); end
      send_frame(2, f8n2(8'h3C, 1'b1), 11, 0, pe);
      checks++; if (pe !== 171) begin errors++; $display("FAIL stop2_latency got edge %0d exp 171", pe); end
      checks++; if (if2.rd_data !== 8'h3C || if2.fifo_count !== 3'd1) begin
         errors++; $display("FAIL stop2_data got %h count %0d exp 3c 1", if2.rd_data, if2.fifo_count); end
   endtask

   initial begin
      tick = 1'b1;
      reset = 1'b1;
      rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      if0.rd_en = 1'b0; if1.rd_en = 1'b0; if2.rd_en = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_glitch();
      test_parity();
      test_overrun();
      test_full_pop();
      test_break();
      test_stop2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
